humidity_sample_sched: RTL and testbench

//   Scheduler that polls N_CH humidity sensor channels round-robin over a shared req/ack bus, once per PERIOD cycles.

---
 rtl/humidity_pkg.sv | 22 ++
 rtl/humidity_sample_sched_hum_avg4.sv | 52 +++++
 rtl/humidity_sample_sched.sv | 165 ++++++++++++++++
 tb/tb_humidity_sample_sched.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/humidity_pkg.sv
// rtl/humidity_pkg.sv - shared types, defaults and helpers for the humidity sample scheduler
package humidity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int HUM_MAX_DEFAULT = 100;

    // Number of bits needed to hold values 0..v-1 (minimum 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/humidity_sample_sched_hum_avg4.sv
// rtl/humidity_sample_sched_hum_avg4.sv - 4-tap moving average of good round results
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           restart the window (fill count to zero)
//   in_valid/in_data    one good round result
//   out_valid/out_data  averaged result, one cycle after the 4th and later inputs; data held otherwise
module hum_avg4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       out_valid,
    output logic [7:0] out_data
);

    logic [7:0] win [4];
    logic [2:0] fill;
    logic       pend;
    logic [9:0] sum;

    assign sum = {2'b00, win[0]} + {2'b00, win[1]} + {2'b00, win[2]} + {2'b00, win[3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) win[i] <= 8'd0;
            fill      <= 3'd0;
            pend      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 8'd0;
        end else if (clear) begin
            fill      <= 3'd0;
            pend      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                win[0] <= in_data;
                win[1] <= win[0];
                win[2] <= win[1];
                win[3] <= win[2];
                if (fill != 3'd4) fill <= fill + 3'd1;
            end
            // The window is full once this input lands on top of three earlier ones.
            pend <= in_valid && (fill >= 3'd3);
            if (pend) begin
                out_data  <= sum[9:2];
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/humidity_sample_sched.sv
// rtl/humidity_sample_sched.sv - round-robin humidity sensor poller reducing each round to its max
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       run enable; low aborts any round and holds the period counter at 0
//   sns_req      one-hot request to the polled sensor; sns_ack/sns_data its response
//   hum_out      round result, held; hum_valid pulses on update
//   ch_fault     per-channel timeout/out-of-range flags
//   all_fault    pulse when a round ends with no good sample
//   overrun      sticky: a period tick hit a busy round
//   busy         high from round start to round end
//   Build option HUM_AVG_EN: hum_out becomes a 4-round moving average of good results.
module humidity_sample_sched
    import humidity_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int PERIOD  = 1000,
    parameter int TIMEOUT = 255,
    parameter int HUM_MAX = HUM_MAX_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    output logic [N_CH-1:0] sns_req,
    input  logic            sns_ack,
    input  logic [7:0]      sns_data,
    output logic [7:0]      hum_out,
    output logic            hum_valid,
    output logic [N_CH-1:0] ch_fault,
    output logic            all_fault,
    output logic            overrun,
    output logic            busy
);

    localparam int GW = clog2(N_CH + 1);
    localparam int CW = clog2(N_CH);
    localparam int PW = clog2(PERIOD);
    localparam int TW = clog2(TIMEOUT + 1);
    localparam logic [7:0]      HMAX8 = 8'(HUM_MAX);
    localparam logic [N_CH-1:0] ONE   = N_CH'(1);

    logic [PW-1:0] per_cnt;
    logic          tick;
    state_t        state;
    logic [CW-1:0] ch;
    logic [TW-1:0] tcnt;
    logic [7:0]    rmax;
    logic [GW-1:0] good;
    logic [7:0]    res_data;
    logic          res_valid;

    assign tick = enable && (per_cnt == PW'(PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
        end else if (!enable || tick) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ch        <= '0;
            tcnt      <= '0;
            rmax      <= 8'd0;
            good      <= '0;
            sns_req   <= '0;
            busy      <= 1'b0;
            ch_fault  <= '0;
            all_fault <= 1'b0;
            overrun   <= 1'b0;
            res_data  <= 8'd0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            all_fault <= 1'b0;
            if (tick && state != IDLE) overrun <= 1'b1;
            if (!enable) begin
                // Abandon the partial round; faults already recorded stay.
                state   <= IDLE;
                sns_req <= '0;
                busy    <= 1'b0;
                ch      <= '0;
                tcnt    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (tick) begin
                            state   <= REQ;
                            ch      <= '0;
                            tcnt    <= '0;
                            rmax    <= 8'd0;
                            good    <= '0;
                            busy    <= 1'b1;
                            sns_req <= ONE;
                        end
                    end
                    REQ: begin
                        tcnt <= tcnt + 1'b1;
                        // Ack is checked first so a response on the expiry cycle is kept.
                        if (sns_ack) begin
                            sns_req <= '0;
                            state   <= GAP;
                            if (sns_data <= HMAX8) begin
                                if (sns_data > rmax) rmax <= sns_data;
                                good         <= good + 1'b1;
                                ch_fault[ch] <= 1'b0;
                            end else begin
                                ch_fault[ch] <= 1'b1;
                            end
                        end else if (tcnt == TW'(TIMEOUT - 1)) begin
                            sns_req      <= '0;
                            state        <= GAP;
                            ch_fault[ch] <= 1'b1;
                        end
                    end
                    GAP: begin
                        if (ch == CW'(N_CH - 1)) begin
                            state <= DONE;
                        end else begin
                            ch      <= ch + 1'b1;
                            tcnt    <= '0;
                            sns_req <= ONE << (ch + 1'b1);
                            state   <= REQ;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (good != '0) begin
                            res_data  <= rmax;
                            res_valid <= 1'b1;
                        end else begin
                            all_fault <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef HUM_AVG_EN
    logic avg_in_valid;

    // Feed the window on the DONE edge itself so the average lands one cycle after the raw result would.
    assign avg_in_valid = enable && (state == DONE) && (good != '0);

    hum_avg4 u_avg (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (!enable),
        .in_valid  (avg_in_valid),
        .in_data   (rmax),
        .out_valid (hum_valid),
        .out_data  (hum_out)
    );
`else
    assign hum_out   = res_data;
    assign hum_valid = res_valid;
`endif

endmodule

// File: tb/tb_humidity_sample_sched.sv
// tb/tb_humidity_sample_sched.sv - randomized self-checking bench for humidity_sample_sched
module tb_humidity_sample_sched;

    localparam int NCH  = 4;
    localparam int PER  = 64;
    localparam int TO   = 8;
    localparam int HMAX = 100;
`ifdef HUM_AVG_EN
    localparam int LAT_V = 3;
`else
    localparam int LAT_V = 2;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable;
    logic           sns_ack;
    logic [7:0]     sns_data;
    logic [NCH-1:0] sns_req;
    logic [7:0]     hum_out;
    logic           hum_valid;
    logic [NCH-1:0] ch_fault;
    logic           all_fault;
    logic           overrun;
    logic           busy;

    logic           ack2 = 1'b0;
    logic [7:0]     data2 = 8'd0;
    logic [NCH-1:0] req2;
    logic [7:0]     hum2;
    logic           hv2, af2, ov2, busy2;
    logic [NCH-1:0] cf2;

    humidity_sample_sched #(.N_CH(NCH), .PERIOD(PER), .TIMEOUT(TO), .HUM_MAX(HMAX)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sns_req(sns_req), .sns_ack(sns_ack),
        .sns_data(sns_data), .hum_out(hum_out), .hum_valid(hum_valid), .ch_fault(ch_fault),
        .all_fault(all_fault), .overrun(overrun), .busy(busy)
    );

    // Short period against silent sensors: every round outlasts the period.
    humidity_sample_sched #(.N_CH(NCH), .PERIOD(16), .TIMEOUT(TO), .HUM_MAX(HMAX)) dut_short (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sns_req(req2), .sns_ack(ack2),
        .sns_data(data2), .hum_out(hum2), .hum_valid(hv2), .ch_fault(cf2),
        .all_fault(af2), .overrun(ov2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sensor behaviour per channel: ack after dly cycles of request (>= TO means never), with dat.
    int dly [NCH];
    int dat [NCH];

    int             cyc = 0;
    int             last_drop = 0;
    int             valid_cnt = 0;
    int             af_cnt = 0;
    int             len [NCH];
    logic           skip_len = 1'b0;
    logic [NCH-1:0] prev_req = '0;

    logic [NCH-1:0] exp_fault = '0;
    int             exp_hum = 0;
    int             hist [$];

    // Sensor responder; also throws stray acks while no request is out.
    initial begin
        int cur, k;
        cur = -1;
        k = 0;
        sns_ack = 1'b0;
        sns_data = 8'd0;
        forever begin
            @(negedge clk);
            if (sns_req == '0) begin
                cur = -1;
                sns_ack = ($urandom_range(0, 3) == 0);
                sns_data = 8'($urandom_range(0, 255));
            end else begin
                int c;
                c = 0;
                for (int i = 0; i < NCH; i++) if (sns_req[i]) c = i;
                if (c != cur) begin
                    cur = c;
                    k = 0;
                end else begin
                    k++;
                end
                if (k == dly[c]) begin
                    sns_ack = 1'b1;
                    sns_data = 8'(dat[c]);
                end else begin
                    sns_ack = 1'b0;
                    sns_data = 8'($urandom_range(0, 255));
                end
            end
        end
    end

    // Cycle monitor: request shape, one-hotness, pulse counts and latency.
    initial begin
        for (int c = 0; c < NCH; c++) len[c] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int c = 0; c < NCH; c++) begin
                if (sns_req[c]) begin
                    len[c]++;
                end else if (prev_req[c]) begin
                    if (!skip_len)
                        check($sformatf("req_len_ch%0d", c), len[c], (dly[c] < TO) ? dly[c] + 1 : TO);
                    len[c] = 0;
                end
            end
            if (prev_req[NCH-1] && !sns_req[NCH-1]) last_drop = cyc;
            if (hum_valid) begin
                valid_cnt++;
                check("valid_latency", cyc - last_drop, LAT_V);
            end
            if (all_fault) begin
                af_cnt++;
                check("all_fault_latency", cyc - last_drop, 2);
            end
            if (rst_n) check("req_onehot", $onehot0(sns_req), 1);
            prev_req = sns_req;
        end
    end

    // Reference: apply the first 'upto' channel outcomes; when complete, derive the round result.
    task automatic model_round(input int upto, input bit complete, output int ev, output int ea);
        int good, mx;
        good = 0;
        mx = 0;
        ev = 0;
        ea = 0;
        for (int c = 0; c < upto; c++) begin
            if (dly[c] < TO && dat[c] <= HMAX) begin
                exp_fault[c] = 1'b0;
                good++;
                if (dat[c] > mx) mx = dat[c];
            end else begin
                exp_fault[c] = 1'b1;
            end
        end
        if (complete) begin
            if (good == 0) begin
                ea = 1;
            end else begin
`ifdef HUM_AVG_EN
                hist.push_back(mx);
                if (hist.size() > 4) void'(hist.pop_front());
                if (hist.size() == 4) begin
                    exp_hum = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
                    ev = 1;
                end
`else
                exp_hum = mx;
                ev = 1;
`endif
            end
        end
    endtask

    task automatic set_round(input int d0, d1, d2, d3, v0, v1, v2, v3);
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
        dat[0] = v0; dat[1] = v1; dat[2] = v2; dat[3] = v3;
    endtask

    task automatic begin_round(input string tag);
        int t;
        t = 0;
        valid_cnt = 0;
        af_cnt = 0;
        while (!busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_start"}, busy, 1);
    endtask

    task automatic finish_round(input string tag);
        int t, ev, ea;
        t = 0;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_end"}, busy, 0);
        repeat (3) @(negedge clk);
        model_round(NCH, 1'b1, ev, ea);
        check({tag, "_hum_valid_pulses"}, valid_cnt, ev);
        check({tag, "_all_fault_pulses"}, af_cnt, ea);
        check({tag, "_hum_out"}, hum_out, exp_hum);
        check({tag, "_ch_fault"}, ch_fault, exp_fault);
    endtask

    task automatic run_round(input string tag);
        begin_round(tag);
        finish_round(tag);
    endtask

    initial begin
        #(20000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, ev, ea;
        rst_n = 1'b0;
        enable = 1'b0;
        set_round(2, 2, 2, 2, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_sns_req", sns_req, 0);
        check("rst_hum_out", hum_out, 0);
        check("rst_hum_valid", hum_valid, 0);
        check("rst_ch_fault", ch_fault, 0);
        check("rst_all_fault", all_fault, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        enable = 1'b1;

        set_round(2, 2, 2, 2, 30, 85, 60, 10);
        run_round("normal");
        set_round(2, 3, 9, 1, 20, 70, 99, 45);
        run_round("ch2_timeout");
        set_round(2, 2, 2, 2, 11, 22, 50, 33);
        run_round("ch2_recover");
        set_round(1, 4, 0, 5, 60, 101, 7, 100);
        run_round("range_edge");
        set_round(9, 9, 9, 9, 1, 2, 3, 4);
        run_round("all_timeout");
        set_round(7, 7, 7, 7, 12, 99, 3, 45);
        run_round("ack_at_expiry");

        // Abort while channel 1 is being polled.
        set_round(2, 7, 2, 2, 33, 44, 55, 66);
        begin_round("drop");
        t = 0;
        while (!sns_req[1] && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("drop_req1_seen", sns_req[1], 1);
        skip_len = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check("drop_sns_req", sns_req, 0);
        check("drop_busy", busy, 0);
        repeat (5) @(negedge clk);
        model_round(1, 1'b0, ev, ea);
        check("drop_hum_valid_pulses", valid_cnt, 0);
        check("drop_all_fault_pulses", af_cnt, 0);
        check("drop_ch_fault", ch_fault, exp_fault);
        hist.delete();
        set_round(9, 9, 9, 9, 0, 0, 0, 0);
        valid_cnt = 0;
        af_cnt = 0;
        enable = 1'b1;
        t = 0;
        while (!busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("reenable_delay", t, PER);
        skip_len = 1'b0;
        finish_round("reenable");

        // Fresh window: maxima 40, 80, 40, 80.
        for (int r = 0; r < 4; r++) begin
            if (r % 2 == 0) set_round(2, 3, 1, 2, 40, 12, 200, 5);
            else            set_round(9, 2, 4, 0, 0, 80, 17, 79);
            run_round($sformatf("window%0d", r));
        end

        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < NCH; c++) begin
                dly[c] = $urandom_range(0, 9);
                dat[c] = $urandom_range(0, 120);
            end
            run_round($sformatf("rand%0d", r));
        end

        check("overrun_normal_period", overrun, 0);
        check("overrun_short_period", ov2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
